fetch_ctrl: RTL and testbench

//  Sequences instruction fetch for the OpenMIPS IF stage: owns the PC, issues word reads to the

---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 68 ++++++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the OpenMIPS instruction fetch controller: widths, reset PC,
// FSM state encodings and the buffered {pc, inst} entry type.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {pc, inst} entries. Flush dominates push and pop;
// push and pop in the same cycle on a full buffer are both honoured.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~flush & ~empty;
    assign do_push_s = push & ~flush & (~full | do_pop_s);

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: PC register, req/gnt/rvalid ROM handshake FSM and instruction buffer.
// Optional FETCH_CTRL_PERF_EN adds saturating fetch/stall performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_flag_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] req_pc_r, req_pc_s;
    logic            outstanding_s;
    logic            room_s;
    logic            grant_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [CNT_W-1:0] count_s;
    fetch_entry_t    wdata_s;
    fetch_entry_t    head_s;

    // Space is reserved for the in-flight word so a response can always be buffered.
    assign outstanding_s = (state_r == ST_WAIT) || (state_r == ST_DRAIN);
    assign room_s        = ~full_s && ((count_s + CNT_W'(outstanding_s)) < CNT_W'(BUF_DEPTH));
    assign mem_req_o     = (state_r == ST_REQ) && room_s;
    assign mem_addr_o    = pc_r;
    assign grant_s       = mem_req_o & mem_gnt_i & ~branch_flag_i;
    assign pop_s         = inst_valid_o & ~stall_i;
    assign wdata_s       = '{pc: req_pc_r, inst: mem_rdata_i};
    assign inst_valid_o  = ~empty_s;
    assign inst_o        = head_s.inst;
    assign pc_o          = head_s.pc;

    // State, PC and address-of-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            req_pc_r <= ZERO_WORD;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            req_pc_r <= req_pc_s;
        end
    end

    // Next-state logic; a redirect always beats a grant or a returning word.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        req_pc_s = req_pc_r;
        push_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
                if (branch_flag_i) pc_s = branch_target_i;
                else               pc_s = pc_r;
            end
            ST_REQ: begin
                if (branch_flag_i) begin
                    pc_s = branch_target_i;
                end else if (grant_s) begin
                    req_pc_s = pc_r;
                    pc_s     = next_pc(pc_r);
                    state_s  = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (branch_flag_i) begin
                    pc_s    = branch_target_i;
                    state_s = mem_rvalid_i ? ST_REQ : ST_DRAIN;
                end else if (mem_rvalid_i) begin
                    push_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (branch_flag_i) pc_s = branch_target_i;
                else               pc_s = pc_r;
                if (mem_rvalid_i)  state_s = ST_REQ;
                else               state_s = ST_DRAIN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (branch_flag_i),
        .wdata (wdata_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_stall_r;

    // Saturating counters of accepted requests and stalled valid cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_r <= 32'h0000_0000;
            perf_stall_r <= 32'h0000_0000;
        end else begin
            if (grant_s && (perf_fetch_r != 32'hFFFF_FFFF)) perf_fetch_r <= perf_fetch_r + 32'h0000_0001;
            else                                            perf_fetch_r <= perf_fetch_r;
            if (inst_valid_o && stall_i && (perf_stall_r != 32'hFFFF_FFFF)) perf_stall_r <= perf_stall_r + 32'h0000_0001;
            else                                                             perf_stall_r <= perf_stall_r;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_r;
    assign perf_stall_cnt_o = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a ROM responder (grant controlled by tests,
// data returned rv_lat+1 cycles after grant as rom(addr)).
module tb_fetch_ctrl;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rv_lat = 0;
    int grants = 0;
    bit pend = 1'b0;
    int pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          stamp;
    } rec_t;
    rec_t q[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .pc_o            (pc_o)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt_o(perf_fetch_cnt_o),
        .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Record every instruction handed to IF/ID.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && inst_valid_o && !stall_i && !branch_flag_i)
            q.push_back('{pc_o, inst_o, cyc});
    end

    // ROM responder.
    always @(posedge clk) begin
        bit g;
        logic [31:0] a;
        g = rst && mem_req_o && mem_gnt_i && !branch_flag_i;
        a = mem_addr_o;
        #1;
        if (g) begin
            pend = 1'b1; pend_cnt = rv_lat; pend_addr = a; grants++;
        end
        mem_rvalid_i = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rom(pend_addr); pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (mem_req_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_pops(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #100;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
        checks++; if ({inst_o, pc_o} !== 64'h0) begin errors++; $display("FAIL reset_inst_pc: got %h/%h expected 0/0", inst_o, pc_o); end
        while ($time < 195) @(negedge clk);
        rst = 1'b1;
        q.delete();
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] e;
        mem_gnt_i = 1'b1;
        wait_pops(8, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d insts expected 8", q.size()); end
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            e = 32'(i) * 32'h4;
            checks++; if (q[i].pc !== e || q[i].inst !== rom(e)) begin
                errors++; $display("FAIL basic_order[%0d]: got %h/%h expected %h/%h", i, q[i].pc, q[i].inst, e, rom(e)); end
            if (i > 0) begin
                checks++; if (q[i].stamp - q[i-1].stamp !== 2) begin
                    errors++; $display("FAIL basic_rate[%0d]: got %0d cycles expected 2", i, q[i].stamp - q[i-1].stamp); end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] held;
        logic [31:0] e;
        int n0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_valid_wait: got 0 expected 1"); end
        stall_i = 1'b1;
        held = pc_o;
        n0 = q.size();
        repeat (10) @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", mem_req_o); end
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== held || inst_o !== rom(held)) begin
            errors++; $display("FAIL stall_hold: got %b %h/%h expected 1 %h/%h", inst_valid_o, pc_o, inst_o, held, rom(held)); end
        checks++; if (mem_addr_o !== held + 32'h8) begin errors++; $display("FAIL stall_full_addr: got %h expected %h", mem_addr_o, held + 32'h8); end
        checks++; if (q.size() !== n0) begin errors++; $display("FAIL stall_no_pop: got %0d expected %0d", q.size(), n0); end
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (perf_stall_cnt_o !== 32'd10) begin errors++; $display("FAIL perf_stall: got %0d expected 10", perf_stall_cnt_o); end
        checks++; if (perf_fetch_cnt_o !== 32'(grants)) begin errors++; $display("FAIL perf_fetch: got %0d expected %0d", perf_fetch_cnt_o, grants); end
`endif
        stall_i = 1'b0;
        wait_pops(n0 + 6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_release_timeout: got %0d expected %0d", q.size(), n0 + 6); end
        for (int i = 0; i < q.size(); i++) begin
            e = 32'(i) * 32'h4;
            checks++; if (q[i].pc !== e || q[i].inst !== rom(e)) begin
                errors++; $display("FAIL stall_order[%0d]: got %h/%h expected %h/%h", i, q[i].pc, q[i].inst, e, rom(e)); end
        end
    endtask

    task automatic test_branch_wait();
        bit ok;
        logic [31:0] e;
        rv_lat = 2;
        wait_req(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bw_req_timeout: got 0 expected 1"); end
        @(negedge clk);
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0100;
        q.delete();
        @(negedge clk);
        branch_flag_i = 1'b0;
        rv_lat = 0;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL bw_flush: got %b expected 0", inst_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL bw_drain_req: got %b expected 0", mem_req_o); end
        wait_pops(4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bw_timeout: got %0d expected 4", q.size()); end
        for (int i = 0; i < q.size(); i++) begin
            e = 32'h100 + 32'(i) * 32'h4;
            checks++; if (q[i].pc !== e || q[i].inst !== rom(e)) begin
                errors++; $display("FAIL bw_order[%0d]: got %h/%h expected %h/%h", i, q[i].pc, q[i].inst, e, rom(e)); end
        end
    endtask

    task automatic test_gnt_delay();
        bit ok;
        logic [31:0] a;
        logic [31:0] e;
        mem_gnt_i = 1'b0;
        wait_req(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gd_req_timeout: got 0 expected 1"); end
        a = mem_addr_o;
        repeat (3) begin
            @(negedge clk);
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== a) begin
                errors++; $display("FAIL gd_stable: got %b/%h expected 1/%h", mem_req_o, mem_addr_o, a); end
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL gd_wait_req: got %b expected 0", mem_req_o); end
        wait_req(20, ok);
        checks++; if (!ok || mem_addr_o !== a + 32'h4) begin
            errors++; $display("FAIL gd_next_addr: got %h expected %h", mem_addr_o, a + 32'h4); end
        wait_pops(q.size() + 3, 40, ok);
        for (int i = 0; i < q.size(); i++) begin
            e = 32'h100 + 32'(i) * 32'h4;
            checks++; if (q[i].pc !== e) begin
                errors++; $display("FAIL gd_order[%0d]: got %h expected %h", i, q[i].pc, e); end
        end
    endtask

    task automatic test_branch_gnt();
        bit ok;
        logic [31:0] e;
        mem_gnt_i = 1'b1;
        wait_req(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bg_req_timeout: got 0 expected 1"); end
        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0200;
        q.delete();
        @(negedge clk);
        branch_flag_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            errors++; $display("FAIL bg_redirect: got %b/%h expected 1/00000200", mem_req_o, mem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL bg_flush: got %b expected 0", inst_valid_o); end
        wait_pops(3, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bg_timeout: got %0d expected 3", q.size()); end
        for (int i = 0; i < q.size(); i++) begin
            e = 32'h200 + 32'(i) * 32'h4;
            checks++; if (q[i].pc !== e || q[i].inst !== rom(e)) begin
                errors++; $display("FAIL bg_order[%0d]: got %h/%h expected %h/%h", i, q[i].pc, q[i].inst, e, rom(e)); end
        end
`ifdef FETCH_CTRL_PERF_EN
        checks++; if (perf_fetch_cnt_o !== 32'(grants)) begin errors++; $display("FAIL bg_perf_fetch: got %0d expected %0d", perf_fetch_cnt_o, grants); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        rv_lat = 1;
        wait_req(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_req_timeout: got 0 expected 1"); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL rm_ctrl: got %b/%b expected 0/0", mem_req_o, inst_valid_o); end
        checks++; if ({mem_addr_o, inst_o, pc_o} !== 96'h0) begin
            errors++; $display("FAIL rm_data: got %h/%h/%h expected 0/0/0", mem_addr_o, inst_o, pc_o); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rv_lat = 0;
        q.delete();
        wait_req(5, ok);
        checks++; if (!ok || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rm_first_addr: got %b/%h expected 1/00000000", ok, mem_addr_o); end
        wait_pops(2, 20, ok);
        checks++; if (!ok || q[0].pc !== 32'h0 || q[1].pc !== 32'h4) begin
            errors++; $display("FAIL rm_restart: got %0d insts expected pcs 0,4", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_gnt_delay();
        test_branch_gnt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
